// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle control unit for the single-issue Datapath. Decodes op/funct
// from the instruction register and walks each instruction through
// FETCH / DCD / EXE / MEMORY / WRITEBACK states, driving every Datapath
// control input each cycle as a Moore decode of the state (plus op/funct).
//
// Parameters
//   HALT_ON_ILLEGAL  1: unsupported op/funct parks the FSM in HALT until rst
//                    0: unsupported op/funct pulses illegal and refetches
//
// Ports
//   clk      in   1  system clock, rising-edge
//   rst      in   1  synchronous reset, active-high
//   op       in   6  IR[31:26]
//   funct    in   6  IR[5:0]
//   zero     in   1  ALU zero flag (combinational from current operands)
//   npcop    out  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
//   PCWr     out  1  PC load enable
//   IRWr     out  1  IR load enable
//   RFWr     out  1  register file write enable
//   aluop    out  4  ALU operation
//   sel      out  1  ALU B source: 0 regB, 1 Imm32
//   extop    out  2  immediate extension: 00 zero, 01 sign, 10 <<16
//   R_sel    out  2  RF write address: 00 rt, 01 rd, 10 $31
//   D_sel    out  2  RF write data: 00 pc, 01 ALU, 10 DM
//   wren     out  1  data memory write enable
//   state    out  4  current state (debug)
//   retire   out  1  pulse in the last state of each instruction
//   illegal  out  1  pulse in DCD on an unsupported op/funct
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] npcop,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic [3:0] aluop,
  output logic       sel,
  output logic [1:0] extop,
  output logic [1:0] R_sel,
  output logic [1:0] D_sel,
  output logic       wren,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DCD    = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_MADR   = 4'd4,
    S_MRD    = 4'd5,
    S_MWR    = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_ALU = 4'd8,
    S_BR     = 4'd9,
    S_JMP    = 4'd10,
    S_HALT   = 4'd15
  } state_e;

  // Opcodes / function codes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_JR    = 6'h08;

  // ALU operations
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_OR     = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0011;
  localparam logic [3:0] ALU_PASS_B = 4'b0100;

  // Mux encodings
  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;
  localparam logic [1:0] RA_RT    = 2'b00;
  localparam logic [1:0] RA_RD    = 2'b01;
  localparam logic [1:0] RA_R31   = 2'b10;
  localparam logic [1:0] WD_PC    = 2'b00;
  localparam logic [1:0] WD_ALU   = 2'b01;
  localparam logic [1:0] WD_DM    = 2'b10;

  state_e state_q, state_d;

  // -------------------------------------------------------------------------
  // Instruction decode (IR is stable from DCD until the next FETCH)
  // -------------------------------------------------------------------------
  logic is_rtype, is_addu, is_subu, is_slt, is_jr;
  logic is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_r_alu, is_i_alu, is_legal;

  assign is_rtype = (op == OP_RTYPE);
  assign is_addu  = is_rtype && (funct == FN_ADDU);
  assign is_subu  = is_rtype && (funct == FN_SUBU);
  assign is_slt   = is_rtype && (funct == FN_SLT);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_addiu = (op == OP_ADDIU);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);

  assign is_r_alu = is_addu || is_subu || is_slt;
  assign is_i_alu = is_addiu || is_ori || is_lui;
  assign is_legal = is_r_alu || is_jr || is_i_alu || is_lw || is_sw ||
                    is_beq || is_j || is_jal;

  // ALU setup shared by EXE_R/EXE_I and held through WB_ALU so the ALU
  // result stays stable while the register file captures it.
  logic [3:0] exe_aluop;
  logic       exe_sel;
  logic [1:0] exe_extop;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    exe_aluop = ALU_ADD;
    exe_sel   = 1'b0;
    exe_extop = EXT_ZERO;
    if (is_subu) begin
      exe_aluop = ALU_SUB;
    end else if (is_slt) begin
      exe_aluop = ALU_SLT;
    end else if (is_addiu) begin
      exe_sel   = 1'b1;
      exe_extop = EXT_SIGN;
    end else if (is_ori) begin
      exe_sel   = 1'b1;
      exe_aluop = ALU_OR;
    end else if (is_lui) begin
      exe_sel   = 1'b1;
      exe_extop = EXT_HI;
      exe_aluop = ALU_PASS_B;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values
    // regardless of process ordering; reset is sampled on the clock edge.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        if (is_r_alu)                   state_d = S_EXE_R;
        else if (is_jr || is_j || is_jal) state_d = S_JMP;
        else if (is_i_alu)              state_d = S_EXE_I;
        else if (is_lw || is_sw)        state_d = S_MADR;
        else if (is_beq)                state_d = S_BR;
        else                            state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_EXE_R, S_EXE_I: state_d = S_WB_ALU;
      S_MADR:           state_d = is_sw ? S_MWR : S_MRD;
      S_MRD:            state_d = S_WB_MEM;
      S_WB_MEM, S_WB_ALU, S_MWR, S_BR, S_JMP: state_d = S_FETCH;
      S_HALT:           state_d = S_HALT;
      default:          state_d = S_FETCH;  // unused encodings recover
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    npcop   = NPC_PC4;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    aluop   = ALU_ADD;
    sel     = 1'b0;
    extop   = EXT_ZERO;
    R_sel   = RA_RT;
    D_sel   = WD_PC;
    wren    = 1'b0;
    retire  = 1'b0;
    illegal = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        IRWr  = 1'b1;
        PCWr  = 1'b1;
        npcop = NPC_PC4;
      end
      S_DCD: illegal = !is_legal;
      S_EXE_R, S_EXE_I: begin
        aluop = exe_aluop;
        sel   = exe_sel;
        extop = exe_extop;
      end
      S_WB_ALU: begin
        aluop  = exe_aluop;
        sel    = exe_sel;
        extop  = exe_extop;
        RFWr   = 1'b1;
        D_sel  = WD_ALU;
        R_sel  = is_rtype ? RA_RD : RA_RT;
        retire = 1'b1;
      end
      S_MADR: begin
        sel   = 1'b1;
        extop = EXT_SIGN;
        aluop = ALU_ADD;
      end
      S_WB_MEM: begin
        RFWr   = 1'b1;
        R_sel  = RA_RT;
        D_sel  = WD_DM;
        retire = 1'b1;
      end
      S_MWR: begin
        wren   = 1'b1;
        sel    = 1'b0;
        retire = 1'b1;
      end
      S_BR: begin
        sel    = 1'b0;
        aluop  = ALU_SUB;
        npcop  = NPC_BR;
        PCWr   = zero;
        retire = 1'b1;
      end
      S_JMP: begin
        PCWr   = 1'b1;
        retire = 1'b1;
        npcop  = is_jr ? NPC_JR : NPC_JMP;
        if (is_jal) begin
          // $31 captures PC+4 on the same edge that loads the target.
          RFWr  = 1'b1;
          R_sel = RA_R31;
          D_sel = WD_PC;
        end
      end
      default: ;  // MRD, HALT and unused encodings: all defaults
    endcase

    // The state register still holds a stale value during the reset cycle,
    // so suppress every side effect until reset is released.
    if (rst) begin
      npcop   = NPC_PC4;
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RFWr    = 1'b0;
      aluop   = ALU_ADD;
      sel     = 1'b0;
      extop   = EXT_ZERO;
      R_sel   = RA_RT;
      D_sel   = WD_PC;
      wren    = 1'b0;
      retire  = 1'b0;
      illegal = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Drives two instances (refetch-on-illegal and halt-on-illegal) with shared
// stimulus and compares every cycle's full control vector against a
// per-instruction expected-cycle list built from the instruction table.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] state;
    logic [1:0] npcop;
    logic       pcwr;
    logic       irwr;
    logic       rfwr;
    logic [3:0] aluop;
    logic       sel;
    logic [1:0] extop;
    logic [1:0] r_sel;
    logic [1:0] d_sel;
    logic       wren;
    logic       retire;
    logic       illegal;
  } out_t;

  typedef enum int {
    K_ADDU, K_SUBU, K_SLT, K_JR, K_ADDIU, K_ORI, K_LUI,
    K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL
  } kind_e;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero;

  logic [1:0] npcop0, npcop1, extop0, extop1, r_sel0, r_sel1, d_sel0, d_sel1;
  logic [3:0] aluop0, aluop1, state0, state1;
  logic       pcwr0, pcwr1, irwr0, irwr1, rfwr0, rfwr1, sel0, sel1;
  logic       wren0, wren1, retire0, retire1, illegal0, illegal1;

  out_t obs0, obs1;
  assign obs0 = {state0, npcop0, pcwr0, irwr0, rfwr0, aluop0, sel0, extop0,
                 r_sel0, d_sel0, wren0, retire0, illegal0};
  assign obs1 = {state1, npcop1, pcwr1, irwr1, rfwr1, aluop1, sel1, extop1,
                 r_sel1, d_sel1, wren1, retire1, illegal1};

  always #5 clk = ~clk;

  mc_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .npcop(npcop0), .PCWr(pcwr0), .IRWr(irwr0), .RFWr(rfwr0), .aluop(aluop0),
    .sel(sel0), .extop(extop0), .R_sel(r_sel0), .D_sel(d_sel0), .wren(wren0),
    .state(state0), .retire(retire0), .illegal(illegal0)
  );

  mc_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .npcop(npcop1), .PCWr(pcwr1), .IRWr(irwr1), .RFWr(rfwr1), .aluop(aluop1),
    .sel(sel1), .extop(extop1), .R_sel(r_sel1), .D_sel(d_sel1), .wren(wren1),
    .state(state1), .retire(retire1), .illegal(illegal1)
  );

  int   checks = 0;
  int   errors = 0;
  bit   halted1 = 1'b0;
  out_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic kind_e classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      case (f)
        6'h21:   return K_ADDU;
        6'h23:   return K_SUBU;
        6'h2A:   return K_SLT;
        6'h08:   return K_JR;
        default: return K_ILL;
      endcase
    end
    case (o)
      6'h09:   return K_ADDIU;
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // Produce an op/funct pair belonging to the given instruction kind; funct
  // is random for non-R instructions since it is immediate bits there.
  task automatic pick_code(input kind_e k, output logic [5:0] o,
                           output logic [5:0] f);
    o = 6'h00;
    f = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU:  f = 6'h21;
      K_SUBU:  f = 6'h23;
      K_SLT:   f = 6'h2A;
      K_JR:    f = 6'h08;
      K_ADDIU: o = 6'h09;
      K_ORI:   o = 6'h0D;
      K_LUI:   o = 6'h0F;
      K_LW:    o = 6'h23;
      K_SW:    o = 6'h2B;
      K_BEQ:   o = 6'h04;
      K_J:     o = 6'h02;
      K_JAL:   o = 6'h03;
      default: begin
        do begin
          o = 6'($urandom_range(0, 63));
          f = 6'($urandom_range(0, 63));
        end while (classify(o, f) != K_ILL);
      end
    endcase
  endtask

  // Expected control vector for every cycle of one instruction.
  task automatic build(input kind_e k, input logic z);
    out_t v;
    exp_q.delete();
    v = '0; v.state = 4'd0; v.pcwr = 1'b1; v.irwr = 1'b1; exp_q.push_back(v);
    v = '0; v.state = 4'd1; v.illegal = (k == K_ILL);    exp_q.push_back(v);
    case (k)
      K_ADDU, K_SUBU, K_SLT: begin
        v = '0; v.state = 4'd2;
        v.aluop = (k == K_ADDU) ? 4'd0 : (k == K_SUBU) ? 4'd1 : 4'd3;
        exp_q.push_back(v);
        v.state = 4'd8; v.rfwr = 1'b1; v.r_sel = 2'b01; v.d_sel = 2'b01;
        v.retire = 1'b1; exp_q.push_back(v);
      end
      K_ADDIU, K_ORI, K_LUI: begin
        v = '0; v.state = 4'd3; v.sel = 1'b1;
        v.extop = (k == K_ADDIU) ? 2'b01 : (k == K_ORI) ? 2'b00 : 2'b10;
        v.aluop = (k == K_ADDIU) ? 4'd0 : (k == K_ORI) ? 4'd2 : 4'd4;
        exp_q.push_back(v);
        v.state = 4'd8; v.rfwr = 1'b1; v.r_sel = 2'b00; v.d_sel = 2'b01;
        v.retire = 1'b1; exp_q.push_back(v);
      end
      K_LW, K_SW: begin
        v = '0; v.state = 4'd4; v.sel = 1'b1; v.extop = 2'b01; exp_q.push_back(v);
        if (k == K_LW) begin
          v = '0; v.state = 4'd5; exp_q.push_back(v);
          v = '0; v.state = 4'd7; v.rfwr = 1'b1; v.d_sel = 2'b10;
          v.retire = 1'b1; exp_q.push_back(v);
        end else begin
          v = '0; v.state = 4'd6; v.wren = 1'b1; v.retire = 1'b1;
          exp_q.push_back(v);
        end
      end
      K_BEQ: begin
        v = '0; v.state = 4'd9; v.aluop = 4'd1; v.npcop = 2'b01;
        v.pcwr = z; v.retire = 1'b1; exp_q.push_back(v);
      end
      K_J, K_JAL, K_JR: begin
        v = '0; v.state = 4'd10; v.pcwr = 1'b1; v.retire = 1'b1;
        v.npcop = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin
          v.rfwr = 1'b1; v.r_sel = 2'b10; v.d_sel = 2'b00;
        end
        exp_q.push_back(v);
      end
      default: ;  // illegal: refetch follows directly
    endcase
  endtask

  // ---------------- stimulus helpers (entered on a falling edge) ----------
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      #1;
      check("rst_en0", {pcwr0, irwr0, rfwr0, wren0, retire0, illegal0}, 0);
      check("rst_en1", {pcwr1, irwr1, rfwr1, wren1, retire1, illegal1}, 0);
      if (i > 0) begin
        check("rst_state0", state0, 0);
        check("rst_state1", state1, 0);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    halted1 = 1'b0;
  endtask

  // Run one instruction; abort_at > 0 stops after that many cycles (the
  // caller then resets).
  task automatic run_code(input logic [5:0] o, input logic [5:0] f,
                          input logic z, input int abort_at);
    kind_e k;
    out_t  halt_v;
    int    n;
    k = classify(o, f);
    build(k, z);
    halt_v = '0;
    halt_v.state = 4'd15;
    n = exp_q.size();
    if (abort_at > 0 && abort_at < n) n = abort_at;
    for (int i = 0; i < n; i++) begin
      op = o; funct = f; zero = z;
      #1;
      check($sformatf("d0 %s c%0d", k.name(), i), obs0, exp_q[i]);
      check($sformatf("d1 %s c%0d", k.name(), i), obs1,
            halted1 ? halt_v : exp_q[i]);
      @(negedge clk);
    end
    if (abort_at == 0 && k == K_ILL) halted1 = 1'b1;
  endtask

  task automatic run_kind(input kind_e k, input logic z);
    logic [5:0] o, f;
    pick_code(k, o, f);
    run_code(o, f, z, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0;
    @(negedge clk);
    do_reset(2);

    run_code(6'h00, 6'h21, 1'b0, 0);   // addu
    run_code(6'h23, 6'h15, 1'b0, 0);   // lw
    run_code(6'h2B, 6'h3F, 1'b1, 0);   // sw
    run_code(6'h04, 6'h00, 1'b1, 0);   // beq taken
    run_code(6'h04, 6'h00, 1'b0, 0);   // beq not taken
    run_code(6'h03, 6'h00, 1'b0, 0);   // jal
    run_code(6'h00, 6'h08, 1'b0, 0);   // jr
    run_code(6'h02, 6'h11, 1'b0, 0);   // j
    run_code(6'h09, 6'h21, 1'b0, 0);   // addiu (funct bits look like addu)
    run_code(6'h0D, 6'h00, 1'b0, 0);   // ori
    run_code(6'h0F, 6'h08, 1'b0, 0);   // lui
    run_code(6'h00, 6'h23, 1'b0, 0);   // subu
    run_code(6'h00, 6'h2A, 1'b0, 0);   // slt

    // Illegal op: refetch on dut0, HALT on dut1 held for 12 cycles.
    run_code(6'h3F, 6'h00, 1'b0, 0);
    run_code(6'h00, 6'h21, 1'b0, 0);
    run_code(6'h23, 6'h00, 1'b0, 0);
    run_code(6'h04, 6'h00, 1'b1, 0);
    do_reset(2);

    // Illegal funct on an R-type.
    run_code(6'h00, 6'h3F, 1'b0, 0);
    run_code(6'h03, 6'h00, 1'b0, 0);
    do_reset(1);

    // Reset in the middle of a lw aborts it; next instruction starts clean.
    run_code(6'h23, 6'h00, 1'b0, 3);
    do_reset(2);
    run_code(6'h00, 6'h21, 1'b0, 0);

    // Randomized instruction stream.
    for (int it = 0; it < 120; it++) begin
      kind_e      k;
      logic [5:0] o, f;
      logic       z;
      k = kind_e'($urandom_range(0, 12));
      z = 1'($urandom_range(0, 1));
      pick_code(k, o, f);
      if ($urandom_range(0, 15) == 0) begin
        run_code(o, f, z, $urandom_range(1, 2));
        do_reset($urandom_range(1, 2));
      end else begin
        run_code(o, f, z, 0);
        if (halted1 && $urandom_range(0, 2) == 0) do_reset($urandom_range(1, 2));
      end
    end
    run_kind(K_BEQ, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
